// File: rtl/video_timing_generator.sv
// Dual raster sync generator: a sensor timebase and a delayed interface timebase,
// each a pixel counter cascaded into a line counter with registered line/frame sync.

module vtg_timebase #(
    parameter int PIX_W           = 12,
    parameter int LINE_W          = 12,
    parameter int PIX_PER_LINE    = 100,
    parameter int LINES_PER_FRAME = 20,
    parameter int SYNC_WIDTH      = 4
) (
    input  logic clk_gen,
    input  logic reset,
    input  logic enable,
    output logic sync_line,
    output logic sync_frame
);

    if (PIX_PER_LINE > (1 << PIX_W)) begin : g_chk_pix_w
        $fatal(1, "vtg_timebase: pixels per line does not fit the pixel counter width");
    end
    if (LINES_PER_FRAME > (1 << LINE_W)) begin : g_chk_line_w
        $fatal(1, "vtg_timebase: lines per frame does not fit the line counter width");
    end
    if (SYNC_WIDTH < 1 || SYNC_WIDTH >= PIX_PER_LINE) begin : g_chk_sync_w
        $fatal(1, "vtg_timebase: line sync width must be in 1..pixels per line - 1");
    end
    if (LINES_PER_FRAME < 2) begin : g_chk_lines
        $fatal(1, "vtg_timebase: at least two lines per frame are required");
    end

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [PIX_W-1:0]  SYNC_END  = PIX_W'(SYNC_WIDTH);

    logic [PIX_W-1:0]  pix_q,  pix_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              sync_line_q,  sync_line_d;
    logic              sync_frame_q, sync_frame_d;

    // Outputs are decoded from the counter values before they advance, so each
    // pin lags its counter by exactly one clock.
    always_comb begin
        pix_d        = pix_q;
        line_d       = line_q;
        sync_line_d  = 1'b0;
        sync_frame_d = 1'b0;
        if (enable) begin
            sync_line_d  = (pix_q < SYNC_END);
            sync_frame_d = (line_q == '0);
            if (pix_q == PIX_LAST) begin
                pix_d  = '0;
                line_d = (line_q == LINE_LAST) ? '0 : line_q + LINE_W'(1);
            end else begin
                pix_d = pix_q + PIX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_gen or negedge reset) begin
        if (!reset) begin
            pix_q        <= '0;
            line_q       <= '0;
            sync_line_q  <= 1'b0;
            sync_frame_q <= 1'b0;
        end else begin
            pix_q        <= pix_d;
            line_q       <= line_d;
            sync_line_q  <= sync_line_d;
            sync_frame_q <= sync_frame_d;
        end
    end

    assign sync_line  = sync_line_q;
    assign sync_frame = sync_frame_q;

endmodule

module video_timing_generator #(
    parameter int bit_cnt_pix_sensor        = 12,
    parameter int bit_cnt_line_sensor       = 12,
    parameter int bit_cnt_pix_interface     = 12,
    parameter int bit_cnt_line_interface    = 12,
    parameter int pix_per_line_sensor       = 100,
    parameter int lines_per_frame_sensor    = 20,
    parameter int line_sync_width_sensor    = 4,
    parameter int pix_per_line_interface    = 80,
    parameter int lines_per_frame_interface = 25,
    parameter int line_sync_width_interface = 8,
    parameter int interface_start_delay     = 10
) (
    input  logic clk_gen,
    input  logic reset,
    output logic sync_line_sensor,
    output logic sync_frame_sensor,
    output logic sync_line_interface,
    output logic sync_frame_interface
);

    localparam int DLY_W = 12;

    if (interface_start_delay < 0 || interface_start_delay > 4095) begin : g_chk_delay
        $fatal(1, "video_timing_generator: interface start delay must be in 0..4095");
    end

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(interface_start_delay);

    logic [DLY_W-1:0] dly_q, dly_d;
    logic             intf_run;

    // Saturating delay: the interface timebase runs once dly_q reaches D, and
    // a fresh reset restarts the wait from zero.
    assign intf_run = (dly_q == DLY_LAST);

    always_comb begin
        dly_d = dly_q;
        if (!intf_run) begin
            dly_d = dly_q + DLY_W'(1);
        end
    end

    always_ff @(posedge clk_gen or negedge reset) begin
        if (!reset) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    vtg_timebase #(
        .PIX_W           (bit_cnt_pix_sensor),
        .LINE_W          (bit_cnt_line_sensor),
        .PIX_PER_LINE    (pix_per_line_sensor),
        .LINES_PER_FRAME (lines_per_frame_sensor),
        .SYNC_WIDTH      (line_sync_width_sensor)
    ) u_sensor (
        .clk_gen    (clk_gen),
        .reset      (reset),
        .enable     (1'b1),
        .sync_line  (sync_line_sensor),
        .sync_frame (sync_frame_sensor)
    );

    vtg_timebase #(
        .PIX_W           (bit_cnt_pix_interface),
        .LINE_W          (bit_cnt_line_interface),
        .PIX_PER_LINE    (pix_per_line_interface),
        .LINES_PER_FRAME (lines_per_frame_interface),
        .SYNC_WIDTH      (line_sync_width_interface)
    ) u_interface (
        .clk_gen    (clk_gen),
        .reset      (reset),
        .enable     (intf_run),
        .sync_line  (sync_line_interface),
        .sync_frame (sync_frame_interface)
    );

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: two instances (defaults, and D=0 with matched
// sensor/interface geometry) checked each clock against an arithmetic raster model.

module tb_video_timing_generator;

    localparam int P_S = 100, L_S = 20, W_S = 4;
    localparam int P_I = 80,  L_I = 25, W_I = 8;
    localparam int D   = 10;

    logic clk_gen = 1'b0;
    logic reset   = 1'b0;
    logic sls_a, sfs_a, sli_a, sfi_a;
    logic sls_b, sfs_b, sli_b, sfi_b;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    always #20 clk_gen = ~clk_gen;

    video_timing_generator u_dut_a (
        .clk_gen              (clk_gen),
        .reset                (reset),
        .sync_line_sensor     (sls_a),
        .sync_frame_sensor    (sfs_a),
        .sync_line_interface  (sli_a),
        .sync_frame_interface (sfi_a)
    );

    video_timing_generator #(
        .pix_per_line_interface    (P_S),
        .lines_per_frame_interface (L_S),
        .line_sync_width_interface (W_S),
        .interface_start_delay     (0)
    ) u_dut_b (
        .clk_gen              (clk_gen),
        .reset                (reset),
        .sync_line_sensor     (sls_b),
        .sync_frame_sensor    (sfs_b),
        .sync_line_interface  (sli_b),
        .sync_frame_interface (sfi_b)
    );

    // Edge e counts rising edges since reset release, starting at 1.
    function automatic logic m_line(int e, int p, int w, int dly);
        if (e <= dly) return 1'b0;
        return ((e - dly - 1) % p) < w;
    endfunction

    function automatic logic m_frame(int e, int p, int l, int dly);
        if (e <= dly) return 1'b0;
        return (((e - dly - 1) / p) % l) == 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_line_sensor",  32'(sls_a), 32'(m_line (k, P_S, W_S, 0)));
        check("a_frame_sensor", 32'(sfs_a), 32'(m_frame(k, P_S, L_S, 0)));
        check("a_line_intf",    32'(sli_a), 32'(m_line (k, P_I, W_I, D)));
        check("a_frame_intf",   32'(sfi_a), 32'(m_frame(k, P_I, L_I, D)));
        check("b_line_sensor",  32'(sls_b), 32'(m_line (k, P_S, W_S, 0)));
        check("b_frame_sensor", 32'(sfs_b), 32'(m_frame(k, P_S, L_S, 0)));
        check("b_line_intf",    32'(sli_b), 32'(m_line (k, P_S, W_S, 0)));
        check("b_frame_intf",   32'(sfi_b), 32'(m_frame(k, P_S, L_S, 0)));
    endtask

    task automatic step();
        @(posedge clk_gen);
        k++;
        @(negedge clk_gen);
        check_all();
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b0;
        #1;
        check("rst_async_a", {28'd0, sls_a, sfs_a, sli_a, sfi_a}, 32'd0);
        check("rst_async_b", {28'd0, sls_b, sfs_b, sli_b, sfi_b}, 32'd0);
        repeat (hold) @(posedge clk_gen);
        #10;
        reset = 1'b1;
        k     = 0;
    endtask

    int ls_rise = 0, ls_high = 0, fs_rise = 0, fs_high = 0;
    int li_rise = 0, li_high = 0, fi_rise = 0, fi_high = 0;
    logic p_ls = 1'b0, p_fs = 1'b0, p_li = 1'b0, p_fi = 1'b0;

    initial begin
        #5;
        check("rst_init", {28'd0, sls_a, sfs_a, sli_a, sfi_a}, 32'd0);
        #5;
        reset = 1'b1;

        // Three frames of each timebase with pulse counting.
        repeat (6100) begin
            step();
            if (k <= 6000) begin
                if (sls_a && !p_ls) ls_rise++;
                if (sls_a)          ls_high++;
                if (sfs_a && !p_fs) fs_rise++;
                if (sfs_a)          fs_high++;
            end
            if (k > D && k <= 6000 + D) begin
                if (sli_a && !p_li) li_rise++;
                if (sli_a)          li_high++;
                if (sfi_a && !p_fi) fi_rise++;
                if (sfi_a)          fi_high++;
            end
            p_ls = sls_a; p_fs = sfs_a; p_li = sli_a; p_fi = sfi_a;
        end
        check("cnt_line_s_pulses",  ls_rise, 60);
        check("cnt_line_s_high",    ls_high, 60 * W_S);
        check("cnt_frame_s_pulses", fs_rise, 3);
        check("cnt_frame_s_high",   fs_high, 3 * P_S);
        check("cnt_line_i_pulses",  li_rise, 75);
        check("cnt_line_i_high",    li_high, 75 * W_I);
        check("cnt_frame_i_pulses", fi_rise, 3);
        check("cnt_frame_i_high",   fi_high, 3 * P_I);

        // Mid-frame reset at edge 537, held three clocks.
        do_reset(1);
        while (k < 537) step();
        do_reset(3);
        repeat (200) step();

        // Randomized reset points and hold lengths.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(30, 2500)) step();
            #($urandom_range(0, 15));
            do_reset($urandom_range(1, 5));
        end
        repeat (300) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
